// File: rtl/down_count_monitor_if.sv
// rtl/down_count_monitor_if.sv - sample/status bundle between the ripple counter side and the monitor.
interface down_count_monitor_if #(
  parameter int WRAP_W = 8,
  parameter int ERR_W  = 8
);
  logic              en;
  logic [3:0]        count_in;
  logic [3:0]        count_q;
  logic              locked;
  logic              tc_pulse;
  logic [WRAP_W-1:0] wrap_cnt;
  logic              err_pulse;
  logic [ERR_W-1:0]  err_cnt;
  logic              stalled;

  modport master (
    output en, count_in,
    input  count_q, locked, tc_pulse, wrap_cnt, err_pulse, err_cnt, stalled
  );

  modport slave (
    input  en, count_in,
    output count_q, locked, tc_pulse, wrap_cnt, err_pulse, err_cnt, stalled
  );
endinterface

// File: rtl/down_count_monitor.sv
// rtl/down_count_monitor.sv - checks a 4-bit down-count stream, locks on clean runs,
// reports wraps, sequence errors and stalls as registered status.
module down_count_monitor #(
  parameter int LOCK_N   = 3,
  parameter int HOLD_MAX = 4,
  parameter int WRAP_W   = 8,
  parameter int ERR_W    = 8
) (
  input  logic                Clk,
  input  logic                ClrN,
  down_count_monitor_if.slave bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACQ   = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [3:0] LOCK_V = 4'(LOCK_N);
  localparam logic [3:0] HOLD_V = 4'(HOLD_MAX);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [3:0]        good_run_q, good_run_d;
  logic [3:0]        hold_run_q, hold_run_d;
  logic              locked_q, locked_d;
  logic              tc_q, tc_d;
  logic              err_pulse_q, err_pulse_d;
  logic [WRAP_W-1:0] wrap_q, wrap_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic              stalled_q, stalled_d;

  logic [3:0] dec_val;
  logic [3:0] good_inc;
  logic       step_dec;
  logic       step_hold;
  logic       step_wrap;

  // A wrap (0 -> 15) is just a correct decrement seen from count 0.
  assign dec_val   = cnt_q - 4'd1;
  assign good_inc  = good_run_q + 4'd1;
  assign step_dec  = (bus.count_in == dec_val);
  assign step_hold = (bus.count_in == cnt_q);
  assign step_wrap = step_dec && (cnt_q == 4'd0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    good_run_d  = good_run_q;
    hold_run_d  = hold_run_q;
    locked_d    = locked_q;
    tc_d        = 1'b0;
    err_pulse_d = 1'b0;
    wrap_d      = wrap_q;
    err_cnt_d   = err_cnt_q;
    stalled_d   = stalled_q;

    if (bus.en) begin
      cnt_d = bus.count_in;
      case (state_q)
        ST_IDLE: begin
          state_d    = ST_ACQ;
          good_run_d = 4'd0;
        end
        ST_ACQ: begin
          if (step_dec) begin
            if (good_inc == LOCK_V) begin
              state_d    = ST_TRACK;
              locked_d   = 1'b1;
              good_run_d = 4'd0;
            end else begin
              good_run_d = good_inc;
            end
          end else if (!step_hold) begin
            good_run_d = 4'd0;
          end
        end
        ST_TRACK: begin
          if (step_wrap) begin
            tc_d = 1'b1;
            if (!(&wrap_q)) wrap_d = wrap_q + 1'b1;
          end else if (!step_dec && !step_hold) begin
            err_pulse_d = 1'b1;
            if (!(&err_cnt_q)) err_cnt_d = err_cnt_q + 1'b1;
            locked_d    = 1'b0;
            good_run_d  = 4'd0;
            state_d     = ST_ACQ;
          end
        end
        default: begin
          state_d    = ST_IDLE;
          good_run_d = 4'd0;
          locked_d   = 1'b0;
        end
      endcase

      // The capture edge out of IDLE has no previous sample to compare against.
      if (state_q == ST_ACQ || state_q == ST_TRACK) begin
        if (step_hold) begin
          hold_run_d = (&hold_run_q) ? hold_run_q : hold_run_q + 4'd1;
        end else begin
          hold_run_d = 4'd0;
        end
        stalled_d = (hold_run_d >= HOLD_V);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!ClrN) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 4'd0;
      good_run_q  <= 4'd0;
      hold_run_q  <= 4'd0;
      locked_q    <= 1'b0;
      tc_q        <= 1'b0;
      err_pulse_q <= 1'b0;
      wrap_q      <= '0;
      err_cnt_q   <= '0;
      stalled_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      good_run_q  <= good_run_d;
      hold_run_q  <= hold_run_d;
      locked_q    <= locked_d;
      tc_q        <= tc_d;
      err_pulse_q <= err_pulse_d;
      wrap_q      <= wrap_d;
      err_cnt_q   <= err_cnt_d;
      stalled_q   <= stalled_d;
    end
  end

  assign bus.count_q   = cnt_q;
  assign bus.locked    = locked_q;
  assign bus.tc_pulse  = tc_q;
  assign bus.wrap_cnt  = wrap_q;
  assign bus.err_pulse = err_pulse_q;
  assign bus.err_cnt   = err_cnt_q;
  assign bus.stalled   = stalled_q;

endmodule

// File: tb/tb_down_count_monitor.sv
// tb/tb_down_count_monitor.sv - directed and random down-count streams against a sequence-rule model,
// driving a wide-counter and a narrow-counter (2-bit) instance in parallel.
module tb_down_count_monitor;

  localparam int LOCK_N   = 3;
  localparam int HOLD_MAX = 4;

  logic Clk  = 1'b0;
  logic ClrN = 1'b0;
  always #5 Clk = ~Clk;

  down_count_monitor_if #(.WRAP_W(8), .ERR_W(8)) if_a ();
  down_count_monitor_if #(.WRAP_W(2), .ERR_W(2)) if_b ();

  down_count_monitor #(.LOCK_N(LOCK_N), .HOLD_MAX(HOLD_MAX), .WRAP_W(8), .ERR_W(8)) dut_a (
    .Clk (Clk),
    .ClrN(ClrN),
    .bus (if_a)
  );

  down_count_monitor #(.LOCK_N(LOCK_N), .HOLD_MAX(HOLD_MAX), .WRAP_W(2), .ERR_W(2)) dut_b (
    .Clk (Clk),
    .ClrN(ClrN),
    .bus (if_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_cmp++;
    if (got !== 32'(exp)) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: "seen" means a previous sample exists; counters kept unbounded, clipped at compare.
  bit m_seen, m_locked, m_tc, m_err, m_stall;
  int m_prev, m_run, m_holds, m_wraps, m_errs;

  function automatic int clip(input int v, input int w);
    int top;
    top = (1 << w) - 1;
    return (v > top) ? top : v;
  endfunction

  task automatic model(input bit clrn, input bit e, input int c);
    bit is_dec, is_hold;
    m_tc  = 0;
    m_err = 0;
    if (!clrn) begin
      m_seen = 0; m_locked = 0; m_stall = 0;
      m_prev = 0; m_run = 0; m_holds = 0; m_wraps = 0; m_errs = 0;
    end else if (e) begin
      if (!m_seen) begin
        m_seen = 1;
        m_run  = 0;
      end else begin
        is_dec  = (c == (m_prev + 15) % 16);
        is_hold = (c == m_prev);
        m_holds = is_hold ? ((m_holds < 15) ? m_holds + 1 : 15) : 0;
        if (!m_locked) begin
          if (is_dec) begin
            m_run++;
            if (m_run == LOCK_N) begin
              m_locked = 1;
              m_run = 0;
            end
          end else if (!is_hold) begin
            m_run = 0;
          end
        end else if (is_dec) begin
          if (m_prev == 0) begin
            m_tc = 1;
            m_wraps++;
          end
        end else if (!is_hold) begin
          m_err = 1;
          m_errs++;
          m_locked = 0;
          m_run = 0;
        end
        m_stall = (m_holds >= HOLD_MAX);
      end
      m_prev = c;
    end
  endtask

  task automatic check_all();
    chk("a.count_q",   if_a.count_q,   m_prev);
    chk("a.locked",    if_a.locked,    m_locked);
    chk("a.tc_pulse",  if_a.tc_pulse,  m_tc);
    chk("a.wrap_cnt",  if_a.wrap_cnt,  clip(m_wraps, 8));
    chk("a.err_pulse", if_a.err_pulse, m_err);
    chk("a.err_cnt",   if_a.err_cnt,   clip(m_errs, 8));
    chk("a.stalled",   if_a.stalled,   m_stall);
    chk("b.locked",    if_b.locked,    m_locked);
    chk("b.tc_pulse",  if_b.tc_pulse,  m_tc);
    chk("b.wrap_cnt",  if_b.wrap_cnt,  clip(m_wraps, 2));
    chk("b.err_pulse", if_b.err_pulse, m_err);
    chk("b.err_cnt",   if_b.err_cnt,   clip(m_errs, 2));
    chk("b.stalled",   if_b.stalled,   m_stall);
  endtask

  task automatic step(input logic clrn, input logic e, input logic [3:0] c);
    ClrN          = clrn;
    if_a.en       = e;
    if_a.count_in = c;
    if_b.en       = e;
    if_b.count_in = c;
    @(posedge Clk);
    model(clrn, e, int'(c));
    #1;
    check_all();
  endtask

  logic [3:0] cur;
  logic [3:0] bad;
  logic       r_en, r_clrn;
  int         r;

  initial begin
    if_a.en = 1'b1; if_a.count_in = 4'd9;
    if_b.en = 1'b1; if_b.count_in = 4'd9;

    step(1'b0, 1'b1, 4'd9);
    step(1'b0, 1'b1, 4'd9);
    chk("rst.count_q", if_a.count_q, 0);
    chk("rst.locked", if_a.locked, 0);
    step(1'b1, 1'b1, 4'd9);
    chk("first.count_q", if_a.count_q, 9);
    chk("first.locked", if_a.locked, 0);

    step(1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b1, 4'd15);
    step(1'b1, 1'b1, 4'd14);
    step(1'b1, 1'b1, 4'd13);
    chk("lock.early", if_a.locked, 0);
    step(1'b1, 1'b1, 4'd12);
    chk("lock.set", if_a.locked, 1);
    for (int v = 11; v >= 0; v--) step(1'b1, 1'b1, 4'(v));
    step(1'b1, 1'b1, 4'd15);
    chk("wrap.tc", if_a.tc_pulse, 1);
    chk("wrap.cnt", if_a.wrap_cnt, 1);
    step(1'b1, 1'b1, 4'd14);
    chk("wrap.tc_drop", if_a.tc_pulse, 0);

    step(1'b1, 1'b1, 4'd9);
    chk("err.pulse", if_a.err_pulse, 1);
    chk("err.cnt", if_a.err_cnt, 1);
    chk("err.unlock", if_a.locked, 0);
    step(1'b1, 1'b1, 4'd7);
    chk("err.acq_quiet", if_a.err_pulse, 0);
    step(1'b1, 1'b1, 4'd6);
    step(1'b1, 1'b1, 4'd5);
    step(1'b1, 1'b1, 4'd4);
    chk("relock", if_a.locked, 1);
    chk("relock.wraps", if_a.wrap_cnt, 1);

    step(1'b0, 1'b1, 4'd0);
    for (int v = 9; v >= 6; v--) step(1'b1, 1'b1, 4'(v));
    for (int k = 0; k < 6; k++) begin
      step(1'b1, 1'b1, 4'd5);
      if (k == 3) chk("stall.before", if_a.stalled, 0);
      if (k == 4) chk("stall.set", if_a.stalled, 1);
    end
    chk("stall.locked", if_a.locked, 1);
    step(1'b1, 1'b1, 4'd4);
    chk("stall.clear", if_a.stalled, 0);

    step(1'b0, 1'b1, 4'd0);
    for (int v = 9; v >= 6; v--) step(1'b1, 1'b1, 4'(v));
    cur = 4'd6;
    for (int i = 0; i < 5; i++) begin
      bad = cur + 4'd5;
      step(1'b1, 1'b1, bad);
      chk("sat.err_b", if_b.err_cnt, (i + 1 > 3) ? 3 : i + 1);
      chk("sat.err_a", if_a.err_cnt, i + 1);
      cur = bad;
      for (int j = 0; j < 3; j++) begin
        cur = cur - 4'd1;
        step(1'b1, 1'b1, cur);
      end
      chk("sat.relock", if_a.locked, 1);
    end

    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 4'($urandom_range(0, 15)));
      chk("hold.locked", if_a.locked, 1);
      chk("hold.count_q", if_a.count_q, int'(cur));
    end
    step(1'b0, 1'b1, 4'd3);
    chk("midrst.locked", if_a.locked, 0);
    chk("midrst.err", if_a.err_cnt, 0);
    chk("midrst.wrap", if_a.wrap_cnt, 0);
    step(1'b1, 1'b1, 4'd7);
    chk("midrst.capture", if_a.count_q, 7);

    cur = 4'd7;
    for (int n = 0; n < 3000; n++) begin
      r      = int'($urandom_range(0, 99));
      r_en   = ($urandom_range(0, 9) != 0);
      r_clrn = ($urandom_range(0, 249) != 0);
      if (r < 72)      cur = cur - 4'd1;
      else if (r < 88) cur = cur;
      else             cur = 4'($urandom_range(0, 15));
      step(r_clrn, r_en, cur);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
